// File: rtl/truth_table_capture.sv
// truth_table_capture: sweeps all eight {in1,in2,in3} combinations into an
// attached 3-input gate, waits a settle time per combination, majority-votes
// the gate output and publishes the resulting 8-bit truth-table code.
// Response to combination k lands in table_code[7-k] (k=000 -> bit 7).
module truth_table_capture #(
  parameter int SETTLE_CYCLES = 4,
  parameter int SAMPLES       = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] expected,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_code,
  output logic       match
);

  // Counter widths: each must hold its terminal count; a 1-bit floor keeps
  // the degenerate parameter values (SETTLE_CYCLES=1, SAMPLES=1) legal.
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int NW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam int OW = $clog2(SAMPLES + 1);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [NW-1:0] SAMPLE_LAST = NW'(SAMPLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  state_t          state;
  logic [2:0]      k;
  logic [SW-1:0]   settle_cnt;
  logic [NW-1:0]   sample_cnt;
  logic [OW-1:0]   ones;
  logic [7:0]      acc;
  logic [7:0]      exp_q;

  logic [OW-1:0]   ones_nxt;
  logic            vote;
  logic [7:0]      acc_nxt;

  // Strict majority of SAMPLES (odd) votes.
  function automatic logic majority(input logic [OW-1:0] count);
    return int'(count) > (SAMPLES / 2);
  endfunction

  // Running ones count including the current sample, and the accumulator
  // as it will look once the vote for combination k is written in.
  always_comb begin
    ones_nxt          = ones + OW'(dut_out);
    vote              = majority(ones_nxt);
    acc_nxt           = acc;
    acc_nxt[3'd7 - k] = vote;
  end

  // Sweep sequencer: stimulus, counters, voting and result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      k               <= 3'd0;
      settle_cnt      <= '0;
      sample_cnt      <= '0;
      ones            <= '0;
      acc             <= 8'h00;
      exp_q           <= 8'h00;
      {in1, in2, in3} <= 3'b000;
      busy            <= 1'b0;
      done            <= 1'b0;
      table_code      <= 8'h00;
      match           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            exp_q           <= expected;
            k               <= 3'd0;
            settle_cnt      <= '0;
            sample_cnt      <= '0;
            ones            <= '0;
            acc             <= 8'h00;
            {in1, in2, in3} <= 3'b000;
            busy            <= 1'b1;
            state           <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        SAMPLE: begin
          if (sample_cnt == SAMPLE_LAST) begin
            sample_cnt <= '0;
            ones       <= '0;
            acc        <= acc_nxt;
            if (k == 3'd7) begin
              // Publish only the complete table; partials never escape.
              table_code      <= acc_nxt;
              match           <= (acc_nxt == exp_q);
              done            <= 1'b1;
              busy            <= 1'b0;
              k               <= 3'd0;
              {in1, in2, in3} <= 3'b000;
              state           <= IDLE;
            end else begin
              k               <= k + 3'd1;
              {in1, in2, in3} <= k + 3'd1;
              state           <= SETTLE;
            end
          end else begin
            sample_cnt <= sample_cnt + NW'(1);
            ones       <= ones_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_capture.sv
// Bench for truth_table_capture: a gate model drives dut_out, a timing-level
// reference model predicts every output each cycle, and directed scenarios
// pin literal results (0xE1 gate, constants, glitches, reset, start handling,
// minimum parameters) before a randomized phase.
module tb_truth_table_capture;

  localparam int S  = 4;
  localparam int N  = 3;
  localparam int WW = S + N;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] expected;
  logic       dut_out;
  logic       in1, in2, in3, busy, done, match;
  logic [7:0] table_code;

  logic       start2;
  logic       dut_out2;
  logic       c_in1, c_in2, c_in3, c_busy, c_done, c_match;
  logic [7:0] c_table_code;

  logic [7:0] gate;
  logic       noise;
  int         glo, ghi;
  int         edge_n = 0;
  bit         chk_en = 0;
  int         n_chk  = 0;
  int         n_err  = 0;
  int         done_q[$];
  int         done2_q[$];

  truth_table_capture #(.SETTLE_CYCLES(S), .SAMPLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .expected(expected),
    .dut_out(dut_out), .in1(in1), .in2(in2), .in3(in3), .busy(busy),
    .done(done), .table_code(table_code), .match(match)
  );

  truth_table_capture #(.SETTLE_CYCLES(1), .SAMPLES(1)) dut_min (
    .clk(clk), .rst_n(rst_n), .start(start2), .expected(8'hE1),
    .dut_out(dut_out2), .in1(c_in1), .in2(c_in2), .in3(c_in3), .busy(c_busy),
    .done(c_done), .table_code(c_table_code), .match(c_match)
  );

  always #5 clk = ~clk;

  // Gate under characterization: truth table lookup plus optional noise/glitch.
  logic [2:0] idx, idx2;
  logic [7:0] gate_e1 = 8'hE1;
  assign idx      = {in1, in2, in3};
  assign idx2     = {c_in1, c_in2, c_in3};
  assign dut_out  = (gate[3'd7 - idx] ^ noise) | ((edge_n >= glo) && (edge_n <= ghi));
  assign dut_out2 = gate_e1[3'd7 - idx2];

  // edge_n is the index of the next rising edge.
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  // ---------------- reference model ----------------
  bit         act_m  = 0;
  int         s_m    = 0;
  int         ones_m[8];
  logic [7:0] cap_m  = 8'h00;
  logic [7:0] tc_m   = 8'h00;
  bit         m_m    = 0;
  bit         done_m = 0;
  bit         busy_m = 0;
  logic [2:0] stim_m = 3'b000;

  always @(negedge rst_n) begin
    act_m = 0; done_m = 0; busy_m = 0; stim_m = 3'b000; tc_m = 8'h00; m_m = 0;
  end

  always @(posedge clk) begin
    int e, o, kk, p;
    e = edge_n;
    if (!rst_n) begin
      act_m = 0; done_m = 0; busy_m = 0; stim_m = 3'b000; tc_m = 8'h00; m_m = 0;
    end else begin
      done_m = 0;
      if (act_m) begin
        o  = e - s_m;
        kk = (o - 1) / WW;
        p  = (o - 1) % WW;
        if (p >= S) ones_m[kk] += int'(dut_out);
        if (o == 8 * WW) begin
          for (int j = 0; j < 8; j++) tc_m[7 - j] = (ones_m[j] > N / 2);
          m_m    = (tc_m == cap_m);
          done_m = 1;
          act_m  = 0;
        end
      end else if (start) begin
        act_m = 1;
        s_m   = e;
        for (int j = 0; j < 8; j++) ones_m[j] = 0;
        cap_m = expected;
      end
      busy_m = act_m;
      stim_m = act_m ? 3'((e - s_m) / WW) : 3'b000;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, busy_m);
      chk("done", done, done_m);
      chk("stim", {in1, in2, in3}, stim_m);
      chk("table_code", table_code, tc_m);
      chk("match", match, m_m);
      if (done === 1'b1) done_q.push_back(edge_n - 1);
      if (c_done === 1'b1) done2_q.push_back(edge_n - 1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One full sweep with a start pulse; returns the start edge.
  task automatic sweep(input logic [7:0] g, input logic [7:0] ex,
                       input int lo, input int hi, output int s);
    gate = g; expected = ex;
    done_q.delete();
    s = edge_n;
    if (lo <= hi) begin glo = s + lo; ghi = s + hi; end
    else begin glo = 1; ghi = 0; end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(60);
    glo = 1; ghi = 0;
    chk("done_count", done_q.size(), 1);
    if (done_q.size() > 0) chk("done_edge", done_q[0] - s, 56);
  endtask

  initial begin
    int s;
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; expected = 8'h00;
    gate = 8'h00; noise = 1'b0; glo = 1; ghi = 0;
    tick(2);
    chk_en = 1;
    rst_n = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_table", table_code, 8'h00);
    chk("rst_stim", {in1, in2, in3}, 3'b000);
    tick(2);

    // 0xE1 gate
    sweep(8'hE1, 8'hE1, 1, 0, s);
    chk("e1_table", table_code, 8'hE1);
    chk("e1_match", match, 1);
    chk("e1_model", tc_m, 8'hE1);

    // constant outputs
    sweep(8'hFF, 8'hE1, 1, 0, s);
    chk("c1_table", table_code, 8'hFF);
    chk("c1_match", match, 0);
    sweep(8'h00, 8'h00, 1, 0, s);
    chk("c0_table", table_code, 8'h00);
    chk("c0_match", match, 1);

    // glitch rejection
    sweep(8'h00, 8'h00, 19, 19, s);
    chk("glitch1_table", table_code, 8'h00);
    sweep(8'h00, 8'h00, 19, 20, s);
    chk("glitch2_table", table_code, 8'h20);
    chk("glitch2_model", tc_m, 8'h20);

    // reset mid-sweep
    sweep(8'hE1, 8'hE1, 1, 0, s);
    gate = 8'hFF;
    s = edge_n;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(20);
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_stim", {in1, in2, in3}, 3'b000);
    chk("rstmid_table", table_code, 8'h00);
    chk("rstmid_match", match, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    sweep(8'hFF, 8'hFF, 1, 0, s);
    chk("after_rst_table", table_code, 8'hFF);

    // start re-pulsed during busy
    gate = 8'hE1; expected = 8'hE1;
    done_q.delete();
    s = edge_n;
    start = 1'b1; tick(1); start = 1'b0;
    tick(9);
    start = 1'b1; tick(1); start = 1'b0;
    tick(55);
    chk("repulse_count", done_q.size(), 1);
    if (done_q.size() > 0) chk("repulse_edge", done_q[0] - s, 56);

    // start held high
    done_q.delete();
    s = edge_n;
    start = 1'b1;
    tick(175);
    start = 1'b0;
    tick(60);
    chk("held_count", done_q.size(), 4);
    if (done_q.size() >= 3) begin
      chk("held_edge0", done_q[0] - s, 56);
      chk("held_edge1", done_q[1] - s, 113);
      chk("held_edge2", done_q[2] - s, 170);
    end

    // minimum parameters
    done2_q.delete();
    s = edge_n;
    start2 = 1'b1; tick(1); start2 = 1'b0;
    tick(20);
    chk("min_count", done2_q.size(), 1);
    if (done2_q.size() > 0) chk("min_edge", done2_q[0] - s, 16);
    chk("min_table", c_table_code, 8'hE1);
    chk("min_match", c_match, 1);

    // randomized phase
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) gate = 8'($urandom);
      expected = ($urandom_range(0, 1) == 1) ? gate : 8'($urandom);
      noise = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
      end
      tick(1);
    end
    start = 1'b0; noise = 1'b0;
    tick(60);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
